// File: rtl/column_pkg.sv
// Shared definitions for the DDA result stream and the per-column store.
package column_pkg;

  // DDA output beat layout: {hcount, lineHeight, wallType, mapData, wallX}
  localparam int DDA_OUT_W  = 38;
  localparam int HCOUNT_LSB = 29;
  localparam int HCOUNT_W   = 9;
  localparam int LH_LSB     = 21;
  localparam int LH_W       = 8;
  localparam int WT_BIT     = 20;
  localparam int MAP_LSB    = 16;
  localparam int MAP_W      = 4;
  localparam int WALLX_LSB  = 0;
  localparam int WALLX_W    = 16;
  localparam int COLUMN_W   = 29;
  // Linear RAM address width; covers two banks of up to 512 columns.
  localparam int ADDR_W     = 10;

  typedef struct packed {
    logic [7:0]  lineHeight;
    logic        wallType;
    logic [3:0]  mapData;
    logic [15:0] wallX;
  } column_t;

  // Extract the stored fields from a DDA beat, clamping lineHeight to the screen.
  function automatic column_t unpack_ray(input logic [DDA_OUT_W-1:0] tdata,
                                         input logic [LH_W-1:0]      max_height);
    column_t c;
    c.lineHeight = (tdata[LH_LSB +: LH_W] > max_height) ? max_height : tdata[LH_LSB +: LH_W];
    c.wallType   = tdata[WT_BIT];
    c.mapData    = tdata[MAP_LSB +: MAP_W];
    c.wallX      = tdata[WALLX_LSB +: WALLX_W];
    return c;
  endfunction

  // Banks are packed back to back so the RAM depth is exactly two frames.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic                bank,
                                                  input logic [HCOUNT_W-1:0] hcount,
                                                  input logic [ADDR_W-1:0]   width);
    return bank ? (width + {1'b0, hcount}) : {1'b0, hcount};
  endfunction

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column RAM: one write port, one read port with a
// registered output stage, giving a 2-cycle read latency.
module column_ram
  import column_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  column_t           wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output column_t           rd_data_o
);

  column_t mem_q [DEPTH];
  column_t rd_stage_q;
  column_t rd_data_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: array read, then output register.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_stage_q <= mem_q[rd_addr_i];
    end
    rd_data_q <= rd_stage_q;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dda_column_store.sv
// Double-buffered per-column store between the DDA output FIFO and the
// column renderer. Rays land in the back bank addressed by hcount; the
// renderer reads the front bank; banks swap at a frame pulse once the back
// bank holds a full frame.
module dda_column_store
  import column_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  input  logic                 col_in_tvalid,
  input  logic [DDA_OUT_W-1:0] col_in_tdata,
  input  logic                 col_in_tlast,
  output logic                 col_in_tready,
  input  logic                 frame_swap_in,
  input  logic                 rd_valid_in,
  input  logic [8:0]           rd_hcount_in,
  output logic                 rd_valid_out,
  output logic [8:0]           rd_hcount_out,
  output logic [7:0]           rd_lineHeight_out,
  output logic                 rd_wallType_out,
  output logic [3:0]           rd_mapData_out,
  output logic [15:0]          rd_wallX_out,
  output logic                 front_bank_out,
  output logic                 back_full_out,
  output logic                 frame_error_out
);

  localparam logic [8:0]        WIDTH_H  = 9'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] WIDTH_A  = 10'(SCREEN_WIDTH);
  localparam logic [9:0]        WIDTH_C  = 10'(SCREEN_WIDTH);
  localparam logic [7:0]        HEIGHT_L = 8'(SCREEN_HEIGHT);

  logic       front_q, front_d;
  logic       back_full_q, back_full_d;
  logic [9:0] wr_count_q, wr_count_d;
  logic       frame_error_q, frame_error_d;

  logic       rd_valid_q1, rd_valid_q2;
  logic       rd_range_q1, rd_range_q2;
  logic [8:0] rd_hcount_q1, rd_hcount_q2;

  logic [8:0] in_hcount;
  logic       beat_acc;
  logic       in_range;
  logic [9:0] wr_count_inc;
  logic       rd_range;
  column_t    ram_rd_data;

  assign in_hcount    = col_in_tdata[HCOUNT_LSB +: HCOUNT_W];
  assign beat_acc     = col_in_tvalid && !back_full_q;
  assign in_range     = in_hcount < WIDTH_H;
  assign wr_count_inc = wr_count_q + {9'd0, in_range};
  assign rd_range     = rd_hcount_in < WIDTH_H;

  // Next-state for bank selection, frame-full flag, write count and error flag.
  // Accepting a beat needs back_full low while a swap needs it high, so the
  // two branches never act in the same cycle.
  always_comb begin
    front_d       = front_q;
    back_full_d   = back_full_q;
    wr_count_d    = wr_count_q;
    frame_error_d = frame_error_q;
    if (beat_acc) begin
      if (col_in_tlast) begin
        back_full_d = 1'b1;
        wr_count_d  = 10'd0;
        if (wr_count_inc != WIDTH_C) begin
          frame_error_d = 1'b1;
        end else begin
          frame_error_d = frame_error_q;
        end
      end else begin
        wr_count_d = wr_count_inc;
      end
    end else begin
      wr_count_d = wr_count_q;
    end
    if (frame_swap_in && back_full_q) begin
      front_d     = ~front_q;
      back_full_d = 1'b0;
    end else begin
      front_d = front_q;
    end
  end

  // Control state registers.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      front_q       <= 1'b0;
      back_full_q   <= 1'b0;
      wr_count_q    <= 10'd0;
      frame_error_q <= 1'b0;
    end else begin
      front_q       <= front_d;
      back_full_q   <= back_full_d;
      wr_count_q    <= wr_count_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Read side-band pipeline: valid, echoed column and in-range flag, aligned
  // with the RAM's two-stage read.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rd_valid_q1  <= 1'b0;
      rd_valid_q2  <= 1'b0;
      rd_range_q1  <= 1'b0;
      rd_range_q2  <= 1'b0;
      rd_hcount_q1 <= 9'd0;
      rd_hcount_q2 <= 9'd0;
    end else begin
      rd_valid_q1  <= rd_valid_in;
      rd_valid_q2  <= rd_valid_q1;
      rd_range_q1  <= rd_valid_in && rd_range;
      rd_range_q2  <= rd_range_q1;
      rd_hcount_q1 <= rd_hcount_in;
      rd_hcount_q2 <= rd_hcount_q1;
    end
  end

  // Bank is taken from front_q in the request cycle, so one read never spans a swap.
  column_ram #(
    .DEPTH(2 * SCREEN_WIDTH)
  ) u_ram (
    .clk_i     (pixel_clk_in),
    .wr_en_i   (beat_acc && in_range && !rst_in),
    .wr_addr_i (bank_addr(~front_q, in_hcount, WIDTH_A)),
    .wr_data_i (unpack_ray(col_in_tdata, HEIGHT_L)),
    .rd_en_i   (rd_valid_in && rd_range && !rst_in),
    .rd_addr_i (bank_addr(front_q, rd_hcount_in, WIDTH_A)),
    .rd_data_o (ram_rd_data)
  );

  assign col_in_tready     = !back_full_q;
  assign front_bank_out    = front_q;
  assign back_full_out     = back_full_q;
  assign frame_error_out   = frame_error_q;
  assign rd_valid_out      = rd_valid_q2;
  assign rd_hcount_out     = rd_hcount_q2;
  assign rd_lineHeight_out = rd_range_q2 ? ram_rd_data.lineHeight : 8'd0;
  assign rd_wallType_out   = rd_range_q2 ? ram_rd_data.wallType   : 1'b0;
  assign rd_mapData_out    = rd_range_q2 ? ram_rd_data.mapData    : 4'd0;
  assign rd_wallX_out      = rd_range_q2 ? ram_rd_data.wallX      : 16'd0;

endmodule
